// File: rtl/bcd_scan_if.sv
// Word handshake plus display outputs of the BCD display scanner.
// A word moves on a rising edge where bcd_valid and bcd_ready are both 1; the source holds bcd_in stable while bcd_valid is high.
interface bcd_scan_if;
    logic        bcd_valid;
    logic [11:0] bcd_in;
    logic        bcd_ready;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        bcd_err;
    logic [1:0]  state;

    modport master (
        output bcd_valid, bcd_in,
        input  bcd_ready, an, seg, frame_done, bcd_err, state
    );

    modport slave (
        input  bcd_valid, bcd_in,
        output bcd_ready, an, seg, frame_done, bcd_err, state
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Latches a 3-digit packed BCD word and time-multiplexes it onto a 3-digit
// 7-segment display with optional leading-zero blanking and an illegal-digit flag.
module bcd_display_scanner #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    bcd_scan_if.slave  bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] word;
    logic [DW-1:0] div;
    logic [1:0]  idx;
    logic [2:0]  blank;
    logic [2:0]  an_r;
    logic [6:0]  seg_r;
    logic        frame_done_r;
    logic        bcd_err_r;

    logic [2:0]  blank_c;
    logic        err_c;
    logic [1:0]  idx_next;
    logic [9:0]  disp_first;
    logic [9:0]  disp_next;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h40;
        endcase
    endfunction

    // Returns {an, seg} for one digit slot; a blanked slot drives nothing.
    function automatic logic [9:0] slot_disp(input logic [1:0] slot,
                                             input logic [11:0] w,
                                             input logic [2:0] bl);
        logic [3:0] d;
        logic [2:0] a;
        case (slot)
            2'd1:    begin d = w[7:4];  a = 3'b010; end
            2'd2:    begin d = w[11:8]; a = 3'b100; end
            default: begin d = w[3:0];  a = 3'b001; end
        endcase
        if (bl[slot[1] ? 2 : (slot[0] ? 1 : 0)])
            slot_disp = 10'd0;
        else
            slot_disp = {a, seg_of(d)};
    endfunction

    // Illegal digits are never zero, so they are never blanked.
    always_comb begin
        blank_c    = 3'b000;
        err_c      = (word[11:8] > 4'd9) || (word[7:4] > 4'd9) || (word[3:0] > 4'd9);
        if (BLANK_LZ) begin
            blank_c[2] = (word[11:8] == 4'd0);
            blank_c[1] = (word[11:8] == 4'd0) && (word[7:4] == 4'd0);
        end
        idx_next   = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
        disp_first = slot_disp(2'd0, word, blank_c);
        disp_next  = slot_disp(idx_next, word, blank);
    end

    assign bus.bcd_ready  = (state != LOAD);
    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.frame_done = frame_done_r;
    assign bus.bcd_err    = bcd_err_r;
    assign bus.state      = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            word         <= 12'd0;
            div          <= '0;
            idx          <= 2'd0;
            blank        <= 3'b000;
            an_r         <= 3'b000;
            seg_r        <= 7'd0;
            frame_done_r <= 1'b0;
            bcd_err_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (bus.bcd_valid && (state != LOAD)) begin
                // A new word aborts any frame in progress; the display holds until E1.
                word  <= bus.bcd_in;
                state <= LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        state     <= SCAN;
                        div       <= '0;
                        idx       <= 2'd0;
                        blank     <= blank_c;
                        bcd_err_r <= err_c;
                        an_r      <= disp_first[9:7];
                        seg_r     <= disp_first[6:0];
                    end
                    SCAN: begin
                        if (idx == 2'd3) begin
                            idx <= 2'd0;
                            div <= '0;
                        end else if (div == DIV_MAX) begin
                            div          <= '0;
                            idx          <= idx_next;
                            an_r         <= disp_next[9:7];
                            seg_r        <= disp_next[6:0];
                            frame_done_r <= (idx == 2'd2);
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
